// File: rtl/alu_defs.sv
// Shared ALU/multiplier constants: control codes, HI/LO selects and the
// multiplier FSM state encoding. The ALU control unit imports the same package.
package alu_defs;

   localparam int WIDTH = 32;

   localparam logic [5:0] CODE_MULTU     = 6'b011001;
   localparam logic [5:0] CODE_OPEN_HILO = 6'b111111;

   localparam logic [1:0] SEL_HI = 2'b01;
   localparam logic [1:0] SEL_LO = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multu_hilo_unit_if.sv
// Bus between the ALU control unit (master) and the multiplier (slave).
// Handshake: the master pulses or holds signal = CODE_MULTU to start; the
// slave raises busy while iterating and done once the product is ready; the
// master then issues CODE_OPEN_HILO (or issued it early during busy) to
// commit, after which hilo_valid stays high and HI/LO are readable through
// sel_hilo. dbg_state exposes the FSM state for observation.
interface multu_hilo_unit_if
   import alu_defs::*;
#(
   parameter int WIDTH = 32
);
   logic [5:0]       signal;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [1:0]       sel_hilo;
   logic [WIDTH-1:0] hilo_out;
   logic             busy;
   logic             done;
   logic             hilo_valid;
   state_t           dbg_state;

   modport master (
      output signal, src_a, src_b, sel_hilo,
      input  hilo_out, busy, done, hilo_valid, dbg_state
   );

   modport slave (
      input  signal, src_a, src_b, sel_hilo,
      output hilo_out, busy, done, hilo_valid, dbg_state
   );
endinterface

// File: rtl/multu_hilo_unit_hilo_reg.sv
// HI/LO register pair with a single 2*WIDTH write port and the sel_hilo
// read mux. Reads are combinational from the registers, so a read on the
// write edge still returns the old value.
module hilo_reg
   import alu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [2*WIDTH-1:0] wdata_i,
   input  logic [1:0]         sel_i,
   output logic [WIDTH-1:0]   rdata_o
);
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   // HI/LO change only on reset or an explicit commit
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (we_i) begin
         hi_q <= wdata_i[2*WIDTH-1:WIDTH];
         lo_q <= wdata_i[WIDTH-1:0];
      end
   end

   // Read decode: unselected and 2'b11 both yield zero
   always_comb begin
      rdata_o = '0;
      case (sel_i)
         SEL_HI:  rdata_o = hi_q;
         SEL_LO:  rdata_o = lo_q;
         default: rdata_o = '0;
      endcase
   end
endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned shift-add multiplier feeding the HI/LO pair.
// One iteration per clock in RUN; the product is committed to HI/LO only
// when the control unit sends OpenHiLo (now or earlier during RUN).
module multu_hilo_unit
   import alu_defs::*;
#(
   parameter int WIDTH = alu_defs::WIDTH,
   parameter int ITER  = WIDTH
) (
   input logic              clk,
   input logic              rst,
   multu_hilo_unit_if.slave bus
);
   localparam int CNT_W = $clog2(ITER);
   localparam int PW    = 2 * WIDTH;

   state_t           state_q;
   logic [PW-1:0]    product_q;
   logic [PW-1:0]    mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CNT_W-1:0] cnt_q;
   logic             open_pending_q;
   logic             hilo_valid_q;

   logic is_multu;
   logic is_open;
   logic commit;

   assign is_multu = (bus.signal == CODE_MULTU);
   assign is_open  = (bus.signal == CODE_OPEN_HILO);
   // A pending early OpenHiLo takes priority over a new MULTU in DONE
   assign commit   = (state_q == S_DONE) && (is_open || open_pending_q);

   // Multiplier FSM and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         product_q      <= '0;
         mcand_q        <= '0;
         mplier_q       <= '0;
         cnt_q          <= '0;
         open_pending_q <= 1'b0;
         hilo_valid_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (is_multu) begin
                  mcand_q        <= {{WIDTH{1'b0}}, bus.src_a};
                  mplier_q       <= bus.src_b;
                  product_q      <= '0;
                  cnt_q          <= '0;
                  open_pending_q <= 1'b0;
                  state_q        <= S_RUN;
               end
            end
            S_RUN: begin
               if (mplier_q[0]) product_q <= product_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               // Remember an early commit request; MULTU is ignored here
               if (is_open) open_pending_q <= 1'b1;
               if (cnt_q == CNT_W'(ITER - 1)) state_q <= S_DONE;
            end
            S_DONE: begin
               if (commit) begin
                  hilo_valid_q   <= 1'b1;
                  open_pending_q <= 1'b0;
                  state_q        <= S_IDLE;
               end else if (is_multu) begin
                  // Uncommitted product is dropped; start over with new operands
                  mcand_q        <= {{WIDTH{1'b0}}, bus.src_a};
                  mplier_q       <= bus.src_b;
                  product_q      <= '0;
                  cnt_q          <= '0;
                  open_pending_q <= 1'b0;
                  state_q        <= S_RUN;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   hilo_reg #(.WIDTH(WIDTH)) u_hilo_reg (
      .clk     (clk),
      .rst     (rst),
      .we_i    (commit),
      .wdata_i (product_q),
      .sel_i   (bus.sel_hilo),
      .rdata_o (bus.hilo_out)
   );

   assign bus.busy       = (state_q == S_RUN);
   assign bus.done       = (state_q == S_DONE);
   assign bus.hilo_valid = hilo_valid_q;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: basic multiply, max operands, early
// commit, restart from DONE, reset mid-run and read decode.
module tb_multu_hilo_unit;
   import alu_defs::*;

   localparam logic [5:0] CODE_NOP = 6'b000000;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   multu_hilo_unit_if #(.WIDTH(32)) bus ();

   multu_hilo_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] st(input state_t s);
      return {62'd0, s};
   endfunction

   // Reads HI or LO through sel_hilo without clocking
   task automatic rd(input logic [1:0] sel, output logic [31:0] val);
      bus.sel_hilo = sel;
      #1;
      val = bus.hilo_out;
   endtask

   // Starts a multiply (MULTU held for E0..E31), then runs E32 with a no-op
   task automatic mul_run(input logic [31:0] a, input logic [31:0] b);
      int busy_cnt;
      busy_cnt     = 0;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.signal   = CODE_MULTU;
      for (int i = 0; i < 32; i++) begin
         step();
         if (bus.busy) busy_cnt++;
      end
      bus.signal = CODE_NOP;
      step();
      check("busy_cycles", 64'(busy_cnt), 64'd32);
      check("done_after_e32", {63'd0, bus.done}, 64'd1);
      check("busy_off_e32", {63'd0, bus.busy}, 64'd0);
   endtask

   task automatic commit_now();
      bus.signal = CODE_OPEN_HILO;
      step();
      bus.signal = CODE_NOP;
      check("commit_valid", {63'd0, bus.hilo_valid}, 64'd1);
      check("commit_state", st(bus.dbg_state), st(S_IDLE));
   endtask

   logic [31:0] v;

   initial begin
      errors       = 0;
      checks       = 0;
      rst          = 1'b1;
      bus.signal   = CODE_NOP;
      bus.src_a    = '0;
      bus.src_b    = '0;
      bus.sel_hilo = 2'b00;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_state", st(bus.dbg_state), st(S_IDLE));
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_valid", {63'd0, bus.hilo_valid}, 64'd0);
      rd(SEL_LO, v); check("rst_lo", {32'd0, v}, 64'd0);
      rd(SEL_HI, v); check("rst_hi", {32'd0, v}, 64'd0);

      // OpenHiLo in IDLE does nothing
      bus.signal = CODE_OPEN_HILO;
      step();
      bus.signal = CODE_NOP;
      check("idle_open_valid", {63'd0, bus.hilo_valid}, 64'd0);
      check("idle_open_state", st(bus.dbg_state), st(S_IDLE));

      // Basic 7*6, read on commit edge sees old LO
      mul_run(32'd7, 32'd6);
      bus.signal = CODE_OPEN_HILO;
      rd(SEL_LO, v); check("basic_lo_pre_commit", {32'd0, v}, 64'd0);
      step();
      bus.signal = CODE_NOP;
      check("basic_valid", {63'd0, bus.hilo_valid}, 64'd1);
      rd(SEL_LO, v); check("basic_lo", {32'd0, v}, 64'd42);
      rd(SEL_HI, v); check("basic_hi", {32'd0, v}, 64'd0);

      // Max operands
      mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      commit_now();
      rd(SEL_HI, v); check("max_hi", {32'd0, v}, 64'hFFFF_FFFE);
      rd(SEL_LO, v); check("max_lo", {32'd0, v}, 64'h0000_0001);

      // Early commit: 9*11, operands change at E5, OpenHiLo at E10, MULTU to the end
      bus.src_a  = 32'd9;
      bus.src_b  = 32'd11;
      bus.signal = CODE_MULTU;
      for (int e = 0; e <= 32; e++) begin
         if (e == 5) begin
            bus.src_a = 32'd100;
            bus.src_b = 32'd100;
         end
         bus.signal = (e == 10) ? CODE_OPEN_HILO : CODE_MULTU;
         step();
      end
      check("early_done", {63'd0, bus.done}, 64'd1);
      rd(SEL_LO, v); check("early_lo_held", {32'd0, v}, 64'h0000_0001);
      step();  // first DONE edge, MULTU still driven
      bus.signal = CODE_NOP;
      check("early_commit_state", st(bus.dbg_state), st(S_IDLE));
      check("early_busy", {63'd0, bus.busy}, 64'd0);
      rd(SEL_LO, v); check("early_lo", {32'd0, v}, 64'd99);
      rd(SEL_HI, v); check("early_hi", {32'd0, v}, 64'd0);

      // Restart from DONE: 3*5 not committed, 4*4 restarts
      mul_run(32'd3, 32'd5);
      mul_run(32'd4, 32'd4);
      rd(SEL_LO, v); check("restart_lo_held", {32'd0, v}, 64'd99);
      commit_now();
      rd(SEL_LO, v); check("restart_lo", {32'd0, v}, 64'd16);
      rd(SEL_HI, v); check("restart_hi", {32'd0, v}, 64'd0);

      // Reset mid-run at E15 of 0x10000*0x10000
      bus.src_a  = 32'h0001_0000;
      bus.src_b  = 32'h0001_0000;
      bus.signal = CODE_MULTU;
      for (int e = 0; e < 15; e++) step();
      check("midrun_busy_pre", {63'd0, bus.busy}, 64'd1);
      rst = 1'b1;
      step();
      rst        = 1'b0;
      bus.signal = CODE_NOP;
      check("midrun_state", st(bus.dbg_state), st(S_IDLE));
      check("midrun_busy", {63'd0, bus.busy}, 64'd0);
      check("midrun_valid", {63'd0, bus.hilo_valid}, 64'd0);
      rd(SEL_HI, v); check("midrun_hi", {32'd0, v}, 64'd0);
      rd(SEL_LO, v); check("midrun_lo", {32'd0, v}, 64'd0);
      bus.signal = CODE_OPEN_HILO;
      step();
      bus.signal = CODE_NOP;
      check("midrun_open_valid", {63'd0, bus.hilo_valid}, 64'd0);
      check("midrun_open_state", st(bus.dbg_state), st(S_IDLE));

      // Read decode with HI = 1, LO = 0
      mul_run(32'h0001_0000, 32'h0001_0000);
      bus.signal = CODE_OPEN_HILO;
      rd(SEL_HI, v); check("decode_hi_commit_edge", {32'd0, v}, 64'd0);
      step();
      bus.signal = CODE_NOP;
      rd(SEL_HI, v); check("decode_hi_after", {32'd0, v}, 64'd1);
      rd(2'b00, v);  check("decode_00", {32'd0, v}, 64'd0);
      rd(2'b01, v);  check("decode_01", {32'd0, v}, 64'd1);
      rd(2'b10, v);  check("decode_10", {32'd0, v}, 64'd0);
      rd(2'b11, v);  check("decode_11", {32'd0, v}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Sequential 32x32 unsigned shift-add multiplier with the HI/LO register pair.
- Responder to the ALU control unit's multiply handshake:
  - the control unit drives a 6-bit signal (MULTU code, then OpenHiLo) to start the multiply and to commit the result;
  - it drives a 2-bit HI/LO select to read HI/LO (MFHI/MFLO).
- Sits beside the ALU in the execute stage. Its read data feeds the same writeback mux as the ALU result.

Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH.
- ITER, 32, shift-add iterations. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- signal  input  6  control code: 6'b011001 = MULTU (start/continue), 6'b111111 = OpenHiLo (commit), anything else = no-op
- src_a  input  WIDTH  multiplicand (rs)
- src_b  input  WIDTH  multiplier (rt)
- sel_hilo  input  2  2'b01 = read HI, 2'b10 = read LO, otherwise no read
- hilo_out  output  WIDTH  selected HI or LO value, 0 when not selected
- busy  output  1  high while an iteration is in progress
- done  output  1  product complete, waiting for commit
- hilo_valid  output  1  HI/LO hold a committed product

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- Reset:
  - state = IDLE; product, mcand, mplier, cnt and HI/LO = 0; open_pending = 0.
  - busy = 0, done = 0, hilo_valid = 0, hilo_out = 0.
  - rst high overrides everything, including mid-RUN. Any operation in flight is discarded.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - On an edge with signal == MULTU: mcand <= {0, src_a} (2*WIDTH bits), mplier <= src_b, product <= 0, cnt <= 0, open_pending <= 0; go to RUN.
  - OpenHiLo and other codes are ignored. HI/LO are unchanged.
- RUN: each edge performs one iteration:
  - if mplier[0], product <= product + mcand (2*WIDTH-bit add; cannot overflow);
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - After the edge with cnt == ITER-1 (the 32nd iteration), go to DONE.
  - The signal value is ignored in RUN, except that OpenHiLo sets open_pending. MULTU does not restart the operation. Operand changes after the start edge have no effect.
- Latency: the start edge is E0. The product is final after E32. done = 1 from E32 onward.
- DONE:
  - If signal == OpenHiLo or open_pending: HI <= product[63:32], LO <= product[31:0], hilo_valid <= 1, open_pending <= 0; go to IDLE. The commit occurs on the first edge in DONE.
  - If signal == MULTU and there is no open_pending: discard the product (HI/LO unchanged), restart exactly as from IDLE (latch new operands), go to RUN.
  - Otherwise stay in DONE and hold the product.
- busy = (state == RUN); done = (state == DONE). Both are registered via state.
- Read path is combinational from the registers: hilo_out = HI if sel_hilo == 01, LO if 10, else 0. sel_hilo == 11 yields 0.
  - A read on the commit edge returns the old value. The new value is visible the cycle after.
- Same-edge events: rst beats everything. In DONE, OpenHiLo/open_pending beats MULTU.
- HI/LO change only on commit or reset.

Decomposition:
- Shared package (alu_defs): CODE_MULTU = 6'b011001, CODE_OPEN_HILO = 6'b111111, SEL_HI = 2'b01, SEL_LO = 2'b10, state encoding (IDLE/RUN/DONE), WIDTH.
  - The ALU control unit uses the same constants.
- One sub-module: hilo_reg. It holds the HI/LO pair, the synchronous reset, the write enable, the 64-bit write data and the sel_hilo read mux.
- The FSM/datapath stays in the top module.

Test Plan:
- Basic: rst, then MULTU with src_a = 32'd7, src_b = 32'd6, held for 32 cycles, then OpenHiLo.
  - Required: busy for exactly 32 cycles; done after E32; commit. sel_hilo = 10 -> 42, sel_hilo = 01 -> 0, hilo_valid = 1.
- Max operands: src_a = src_b = 32'hFFFFFFFF.
  - Required: HI = 32'hFFFFFFFE, LO = 32'h00000001.
- Early commit: OpenHiLo at E10 during RUN, then MULTU until the end.
  - Required: open_pending is set; commit on the first DONE edge. HI/LO = product of operands latched at E0. Operands changed at E5 have no effect.
- Restart from DONE: 3*5 completes; MULTU with 4*4 and no OpenHiLo.
  - Required: HI/LO stay at the previous committed value; the new run produces 16 after its commit.
- Reset mid-run: rst asserted at E15 of 0x10000*0x10000.
  - Required: state IDLE; busy = 0; HI = LO = 0; hilo_valid = 0; a later OpenHiLo with no run does nothing.
- Read decode: after a committed HI = 1, LO = 0: sel_hilo 00 -> 0, 01 -> 1, 10 -> 0, 11 -> 0. A read on the commit edge returns the old value.
